// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the fetch/data memory arbiter.
//   arb_state_t : priority state of the aging FSM (data first / fetch first)
//   SRC_F/SRC_D : encoding of the requester that owns an outstanding read
//   CNT_MAX     : saturation value of the 4-bit fetch wait counter
package mem_arb_pkg;

  typedef enum logic {
    D_PRI = 1'b0,
    F_PRI = 1'b1
  } arb_state_t;

  localparam logic       SRC_F   = 1'b0;
  localparam logic       SRC_D   = 1'b1;
  localparam logic [3:0] CNT_MAX = 4'd15;

endpackage

// File: rtl/arb_age_counter.sv
// arb_age_counter: counts consecutive cycles in which fetch requests but is
// denied, and raises fetch_priority once that count reaches MAX_WAIT.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   f_req           fetch is requesting this cycle
//   f_gnt           fetch was granted this cycle
//   fetch_priority  1 = fetch wins a conflict this cycle (state F_PRI)
module arb_age_counter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic f_req,
  input  logic f_gnt,
  output logic fetch_priority
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  arb_state_t state;
  arb_state_t state_next;
  logic [3:0] wait_cnt;
  logic [3:0] wait_cnt_next;

  // Next wait count and next priority state.
  always_comb begin
    wait_cnt_next = 4'd0;
    state_next    = state;
    if (f_req && !f_gnt) begin
      if (wait_cnt == CNT_MAX) begin
        wait_cnt_next = CNT_MAX;
      end else begin
        wait_cnt_next = wait_cnt + 4'd1;
      end
    end else begin
      wait_cnt_next = 4'd0;
    end
    case (state)
      D_PRI: begin
        // Switch on the cycle the count reaches the threshold so fetch wins
        // the very next conflict.
        if (wait_cnt_next >= MAX_WAIT_C) begin
          state_next = F_PRI;
        end else begin
          state_next = D_PRI;
        end
      end
      F_PRI: begin
        // Priority is spent on a grant and is not kept if fetch withdraws.
        if (f_gnt || !f_req) begin
          state_next = D_PRI;
        end else begin
          state_next = F_PRI;
        end
      end
      default: state_next = D_PRI;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= D_PRI;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  assign fetch_priority = (state == F_PRI);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory between the
// instruction-fetch port (F, reads only) and the data port (D, loads/stores).
// Data wins conflicts unless fetch has aged into priority. Read data returns
// one cycle after grant and is steered to the requester that issued the read.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   f_req/f_addr -> f_gnt               fetch request handshake
//   f_rvalid/f_rdata                    fetch read return
//   d_req/d_we/d_addr/d_wdata -> d_gnt  data request handshake
//   d_rvalid/d_rdata                    load read return
//   mem_en/mem_we/mem_addr/mem_wdata    memory command
//   mem_rdata                           memory read data (1 cycle after read)
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic fetch_priority;
  logic rd_pending;
  logic rd_src;

  arb_age_counter #(
    .MAX_WAIT(MAX_WAIT)
  ) u_age (
    .clk           (clk),
    .reset         (reset),
    .f_req         (f_req),
    .f_gnt         (f_gnt),
    .fetch_priority(fetch_priority)
  );

  // Grant selection and memory command mux.
  always_comb begin
    f_gnt     = 1'b0;
    d_gnt     = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (reset) begin
      f_gnt = 1'b0;
      d_gnt = 1'b0;
    end else if (f_req && d_req) begin
      f_gnt = fetch_priority;
      d_gnt = !fetch_priority;
    end else begin
      f_gnt = f_req;
      d_gnt = d_req;
    end
    if (d_gnt) begin
      mem_addr = d_addr;
      if (d_we) begin
        mem_wdata = d_wdata;
      end else begin
        mem_wdata = '0;
      end
    end else if (f_gnt) begin
      mem_addr = f_addr;
    end else begin
      mem_addr = '0;
    end
  end

  assign mem_en = f_gnt | d_gnt;
  assign mem_we = d_gnt & d_we;

  // Remember which requester owns the read issued this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pending <= 1'b0;
      rd_src     <= SRC_F;
    end else begin
      rd_pending <= f_gnt | (d_gnt & !d_we);
      rd_src     <= d_gnt ? SRC_D : SRC_F;
    end
  end

  // A read granted just before reset must not be reported during reset.
  assign f_rvalid = rd_pending & (rd_src == SRC_F) & !reset;
  assign d_rvalid = rd_pending & (rd_src == SRC_D) & !reset;
  assign f_rdata  = f_rvalid ? mem_rdata : '0;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk;
  logic        reset;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic [31:0] f_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        src;    // 0 = fetch, 1 = data
    logic [31:0] data;
    int          stamp;  // cycle in which the read was granted
  } exp_t;

  exp_t        sb[$];
  logic [31:0] env_mem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          run = 0;      // consecutive denied fetch cycles (reference)
  logic        last_f = 1'b0;
  logic        last_d = 1'b0;
  logic        act_f = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Environment memory: single-port, read data one cycle after a read.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) env_mem[mem_addr] = mem_wdata;
      else mem_rdata <= env_mem[mem_addr];
    end else begin
      mem_rdata <= $urandom;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: fetch wins a conflict once denied MAX_WAIT cycles in a row.
  task automatic model();
    logic ef, ed;
    ef = !reset && f_req && (!d_req || run >= MAX_WAIT);
    ed = !reset && d_req && !ef;
    check("f_gnt", 32'(f_gnt), 32'(ef));
    check("d_gnt", 32'(d_gnt), 32'(ed));
    check("mem_en", 32'(mem_en), 32'(ef | ed));
    check("mem_we", 32'(mem_we), 32'(ed & d_we));
    if (ed) check("mem_addr_d", mem_addr, d_addr);
    else if (ef) check("mem_addr_f", mem_addr, f_addr);
    check("mem_wdata", mem_wdata, (ed && d_we) ? d_wdata : 32'd0);
    if (reset) run = 0;
    else if (f_req && !ef) run = (run < 15) ? run + 1 : 15;
    else run = 0;
    if (ef) sb.push_back('{1'b0, ref_mem[f_addr], cyc});
    if (ed) begin
      if (d_we) ref_mem[d_addr] = d_wdata;
      else sb.push_back('{1'b1, ref_mem[d_addr], cyc});
    end
    last_f = ef;
    last_d = ed;
    act_f  = f_gnt;
  endtask

  task automatic step();
    @(negedge clk);
    model();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every rvalid must match the oldest outstanding read.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      check("rvalid_in_reset", 32'({f_rvalid, d_rvalid}), 32'd0);
      while (sb.size() > 0 && sb[0].stamp < cyc) void'(sb.pop_front());
    end else begin
      if (f_rvalid || d_rvalid) begin
        if (sb.size() == 0 || sb[0].stamp >= cyc) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rvalid: got f=%b d=%b expected none", f_rvalid, d_rvalid);
        end else begin
          e = sb.pop_front();
          check("rvalid_src", 32'({f_rvalid, d_rvalid}), e.src ? 32'd1 : 32'd2);
          check("rdata", e.src ? d_rdata : f_rdata, e.data);
        end
      end else if (sb.size() > 0 && sb[0].stamp < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_rvalid: got none expected src=%b data=%h", sb[0].src, sb[0].data);
        void'(sb.pop_front());
      end
      if (!f_rvalid) check("f_rdata_idle", f_rdata, 32'd0);
      if (!d_rvalid) check("d_rdata_idle", d_rdata, 32'd0);
    end
  end

  initial begin
    logic [31:0] mask;
    logic [31:0] v;
    reset = 1'b1; f_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    f_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
    for (int i = 0; i < 8; i++) begin
      v = $urandom;
      env_mem[32'(i) << 2] = v;
      ref_mem[32'(i) << 2] = v;
    end
    env_mem[32'h40] = 32'hDEADBEEF;  ref_mem[32'h40] = 32'hDEADBEEF;
    env_mem[32'h100] = 32'h0;        ref_mem[32'h100] = 32'h0;
    #1;

    // Reset held two cycles with both requesting, then data wins first.
    step(); step();
    reset = 1'b0;
    step();
    f_req = 1'b0; d_req = 1'b0;
    step();

    // Fetch only.
    f_addr = 32'h40; f_req = 1'b1;
    step();
    f_req = 1'b0;
    step();

    // Store then load back-to-back.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h12345678;
    step();
    d_we = 1'b0;
    step();
    d_req = 1'b0;
    step();

    // Starvation: fetch granted on every fifth conflict cycle.
    f_req = 1'b1; d_req = 1'b1; f_addr = 32'h0; d_addr = 32'h4; d_we = 1'b0;
    mask = 32'h0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (act_f) mask[i] = 1'b1;
    end
    check("starve_pattern", mask, 32'h0000_4210);
    f_req = 1'b0; d_req = 1'b0;
    step();

    // Priority not banked: a dropped request restarts the wait.
    f_req = 1'b1; d_req = 1'b1;
    step(); step(); step();
    f_req = 1'b0;
    step();
    f_req = 1'b1;
    mask = 32'h0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (act_f) mask[i] = 1'b1;
    end
    check("not_banked_pattern", mask, 32'h0000_0010);
    f_req = 1'b0; d_req = 1'b0;
    step();

    // Reset the cycle after a fetch read grant.
    f_req = 1'b1; f_addr = 32'h8;
    step();
    reset = 1'b1; f_req = 1'b0;
    step();
    reset = 1'b0;
    step();
    f_req = 1'b1; d_req = 1'b1;
    mask = 32'h0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (act_f) mask[i] = 1'b1;
    end
    check("after_reset_pattern", mask, 32'h0000_0010);
    f_req = 1'b0; d_req = 1'b0;
    step();

    // Random traffic; requests held until granted, occasional reset pulses.
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      if (!f_req || last_f) begin
        f_req  = ($urandom_range(0, 99) < 60);
        f_addr = 32'($urandom_range(0, 7)) << 2;
      end
      if (!d_req || last_d) begin
        d_req   = ($urandom_range(0, 99) < 70);
        d_we    = ($urandom_range(0, 99) < 40);
        d_addr  = 32'($urandom_range(0, 7)) << 2;
        d_wdata = $urandom;
      end
      step();
    end

    reset = 1'b0; f_req = 1'b0; d_req = 1'b0;
    step(); step(); step();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
